onchip_mem2p: RTL and testbench

ONCHIP_MEM2P -- requirements
Module: onchip_mem2p

---
 rtl/onchip_mem2p.sv | 162 ++++++++++++++++
 tb/tb_onchip_mem2p.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem2p.sv
// onchip_mem2p -- two-port arbitrated single-array on-chip memory.
//
// One storage array of 2**ADDR_WIDTH words is shared by two request/ack
// ports (A and B). A three-state FSM (IDLE -> ACCESS -> ACK) serves one
// access at a time. Simultaneous requests are resolved round robin.
//
// Timing: a request sampled at edge N is granted and latched. The array is
// accessed at edge N+1. The ack and the read data are visible during cycle
// N+2. At most one access completes every three cycles.
//
// Optional feature: define ONCHIP_MEM_PARITY_EN to widen the array by one
// even-parity bit per word.
//   - par_inj inverts the stored parity bit on writes.
//   - par_err pulses with a read ack whose parity check fails.
// With the macro undefined, par_inj is ignored and par_err is tied low.
//
// Ports:
//   clk                 in   single clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   a_req / b_req       in   access request, held until ack
//   a_we / b_we         in   1 = write, 0 = read
//   a_addr / b_addr     in   word address
//   a_wdata / b_wdata   in   write data
//   a_ack / b_ack       out  one-cycle completion pulse
//   a_rdata / b_rdata   out  per-port registered read data
//   par_inj             in   parity inject (test only)
//   par_err             out  parity error pulse, coincident with read ack
module onchip_mem2p #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  par_inj,
  output logic                  par_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  logic [MEM_W-1:0]      r_mem [DEPTH];
  state_t                r_state;
  logic                  r_gnt_b;   // current grant belongs to port B
  logic                  r_last_b;  // previous grant went to port B
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_par_err;

  logic                  w_pick_b;
  logic [MEM_W-1:0]      w_wr_word;
  logic [MEM_W-1:0]      w_rd_word;
  logic                  w_rd_par_bad;

  // B wins when alone, or on a tie when A had the previous grant.
  assign w_pick_b  = b_req & (~a_req | ~r_last_b);
  assign w_rd_word = r_mem[r_addr];

`ifdef ONCHIP_MEM_PARITY_EN
  logic r_inj;
  // Even parity over data plus parity bit.
  // The inject flag flips the stored bit so the next read of the word flags an error.
  assign w_wr_word    = {(^r_wdata) ^ r_inj, r_wdata};
  assign w_rd_par_bad = ^w_rd_word;
`else
  logic w_unused_par_inj;
  assign w_unused_par_inj = par_inj;
  assign w_wr_word        = r_wdata;
  assign w_rd_par_bad     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_gnt_b   <= 1'b0;
      r_last_b  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_par_err <= 1'b0;
`ifdef ONCHIP_MEM_PARITY_EN
      r_inj     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_a_ack   <= 1'b0;
          r_b_ack   <= 1'b0;
          r_par_err <= 1'b0;
          if (a_req | b_req) begin
            r_gnt_b  <= w_pick_b;
            r_last_b <= w_pick_b;
            r_we     <= w_pick_b ? b_we    : a_we;
            r_addr   <= w_pick_b ? b_addr  : a_addr;
            r_wdata  <= w_pick_b ? b_wdata : a_wdata;
`ifdef ONCHIP_MEM_PARITY_EN
            r_inj    <= par_inj;
`endif
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            if (r_gnt_b) r_b_rdata <= w_rd_word[DATA_WIDTH-1:0];
            else         r_a_rdata <= w_rd_word[DATA_WIDTH-1:0];
            r_par_err <= w_rd_par_bad;
          end
          r_a_ack <= ~r_gnt_b;
          r_b_ack <= r_gnt_b;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_a_ack   <= 1'b0;
          r_b_ack   <= 1'b0;
          r_par_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array write.
  // An asynchronous reset forces r_state to IDLE, so a write caught in
  // ACCESS at reset is never committed.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we) r_mem[r_addr] <= w_wr_word;
  end

  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign par_err = r_par_err;

endmodule

// File: tb/tb_onchip_mem2p.sv
module tb_onchip_mem2p;

  localparam int DW = 36;
  localparam int AW = 14;

  logic          clk;
  logic          reset_n;
  logic          a_req, a_we, a_ack;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_ack;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          par_inj, par_err;

  int n_cmp = 0;
  int n_err = 0;

  onchip_mem2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .par_inj(par_inj), .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on port A (pb=0) or B (pb=1), starting just after a negedge.
  // Checks two-cycle latency, a single-cycle ack and silence on the other port.
  task automatic acc(input bit pb, input bit we, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd, input bit inj, input string tag,
                     output logic [DW-1:0] rd, output logic pe);
    int lat;
    bit got;
    par_inj = inj;
    if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    lat = 0;
    got = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if ((pb ? b_ack : a_ack) === 1'b1) got = 1;
    end
    rd = pb ? b_rdata : a_rdata;
    pe = par_err;
    chk({tag, "_other_ack"}, 64'(pb ? a_ack : b_ack), 64'd0);
    if (pb) b_req = 0; else a_req = 0;
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    @(negedge clk);
    chk({tag, "_ackpulse"}, 64'(pb ? b_ack : a_ack), 64'd0);
  endtask

  logic [DW-1:0] rd;
  logic          pe;
  logic [DW-1:0] d1;
  int            lat;
  int            ev_cyc [4];
  bit            ev_b [4];
  int            n_ev;

  initial begin
    d1 = 36'o123456701234;
    reset_n = 0; par_inj = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_ack", 64'(a_ack), 64'd0);
    chk("rst_b_ack", 64'(b_ack), 64'd0);
    chk("rst_a_rdata", 64'(a_rdata), 64'd0);
    chk("rst_b_rdata", 64'(b_rdata), 64'd0);
    chk("rst_par_err", 64'(par_err), 64'd0);
    reset_n = 1;
    @(negedge clk);

    // A writes, B reads back the same word
    acc(0, 1, 14'o17, d1, 0, "t30_aw", rd, pe);
    acc(1, 0, 14'o17, '0, 0, "t30_br", rd, pe);
    chk("t30_b_rdata", 64'(rd), 64'(d1));
    chk("t30_a_rdata", 64'(a_rdata), 64'd0);
    chk("t30_par_err", 64'(pe), 64'd0);

    // rdata holds across writes and other-port accesses
    acc(0, 1, 14'o20, 36'o5, 0, "hold_aw", rd, pe);
    chk("hold_b_after_aw", 64'(b_rdata), 64'(d1));
    acc(0, 0, 14'o17, '0, 0, "hold_ar", rd, pe);
    chk("hold_a_read", 64'(rd), 64'(d1));
    acc(1, 1, 14'o17, 36'o42, 0, "hold_bw", rd, pe);
    chk("hold_a_after_bw", 64'(a_rdata), 64'(d1));
    chk("hold_b_after_bw", 64'(b_rdata), 64'(d1));

    // Reset clears rdata but not the array; simultaneous requests, A first
    reset_n = 0;
    @(negedge clk);
    chk("rst2_a_rdata", 64'(a_rdata), 64'd0);
    chk("rst2_b_rdata", 64'(b_rdata), 64'd0);
    reset_n = 1;
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 14'o5; a_wdata = 36'o1;
    b_req = 1; b_we = 0; b_addr = 14'o5;
    lat = 0;
    while (a_ack !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    chk("t31_a_lat", 64'(lat), 64'd2);
    chk("t31_b_wait", 64'(b_ack), 64'd0);
    a_req = 0;
    lat = 0;
    while (b_ack !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    chk("t31_b_gap", 64'(lat), 64'd3);
    chk("t31_b_rdata", 64'(b_rdata), 64'o1);
    b_req = 0;
    @(negedge clk);
    chk("t31_b_ackpulse", 64'(b_ack), 64'd0);

    // Continuous contention: acks alternate A,B,A,B three cycles apart
    a_req = 1; a_we = 1; a_addr = 14'd20; a_wdata = 36'o11;
    b_req = 1; b_we = 1; b_addr = 14'd21; b_wdata = 36'o22;
    n_ev = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((a_ack === 1'b1 || b_ack === 1'b1) && n_ev < 4) begin
        ev_cyc[n_ev] = c;
        ev_b[n_ev]   = (b_ack === 1'b1);
        n_ev++;
      end
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
    chk("t32_n_acks", 64'(n_ev), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t32_port_%0d", i), 64'(ev_b[i]), 64'(i % 2));
      chk($sformatf("t32_cyc_%0d", i), 64'(ev_cyc[i]), 64'(2 + 3 * i));
    end
    acc(0, 0, 14'd20, '0, 0, "t32_ra", rd, pe);
    chk("t32_ra_data", 64'(rd), 64'o11);
    acc(1, 0, 14'd21, '0, 0, "t32_rb", rd, pe);
    chk("t32_rb_data", 64'(rd), 64'o22);

    // Reset during ACCESS of a write aborts it
    acc(0, 1, 14'o10, 36'o555, 0, "t33_pre", rd, pe);
    a_req = 1; a_we = 1; a_addr = 14'o10; a_wdata = 36'o777;
    @(negedge clk);
    chk("t33_in_access_ack", 64'(a_ack), 64'd0);
    reset_n = 0;
    @(negedge clk);
    a_req = 0;
    reset_n = 1;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_ack === 1'b1) lat++;
    end
    chk("t33_no_ack", 64'(lat), 64'd0);
    acc(0, 0, 14'o10, '0, 0, "t33_rd", rd, pe);
    chk("t33_prior_data", 64'(rd), 64'o555);

    // Max address and address 0 are distinct words
    acc(0, 1, 14'd0, 36'o1234, 0, "t35_w0", rd, pe);
    acc(0, 1, 14'h3FFF, {DW{1'b1}}, 0, "t35_wmax", rd, pe);
    acc(1, 0, 14'h3FFF, '0, 0, "t35_rmax", rd, pe);
    chk("t35_max_data", 64'(rd), 64'(36'hF_FFFF_FFFF));
    acc(0, 0, 14'd0, '0, 0, "t35_r0", rd, pe);
    chk("t35_zero_data", 64'(rd), 64'o1234);

    // Parity inject
    acc(0, 1, 14'o3, 36'o7, 1, "t34_winj", rd, pe);
    acc(0, 0, 14'o3, '0, 0, "t34_rinj", rd, pe);
    chk("t34_inj_data", 64'(rd), 64'o7);
`ifdef ONCHIP_MEM_PARITY_EN
    chk("t34_inj_par_err", 64'(pe), 64'd1);
`else
    chk("t34_inj_par_err", 64'(pe), 64'd0);
`endif
    acc(0, 1, 14'o3, 36'o7, 0, "t34_wclean", rd, pe);
    acc(0, 0, 14'o3, '0, 0, "t34_rclean", rd, pe);
    chk("t34_clean_data", 64'(rd), 64'o7);
    chk("t34_clean_par_err", 64'(pe), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
